// File: rtl/pipe_skid_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage_pkg
//   Shared pipeline definitions: skid-stage state encoding, occupancy width,
//   per-stage payload width defaults and the state -> occupancy helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package pipe_skid_stage_pkg;

    // Held-payload state of a two-entry skid stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_BUSY  = 2'd1,   // main valid
        ST_FULL  = 2'd2    // main and skid valid
    } skid_state_e;

    localparam int OCC_W = 2;

    // Per-stage payload widths (rd_addr, rd_data, s_data, optype, opname).
    localparam int SKID_DATA_W    = 80;
    localparam int DECODE_DATA_W  = 80;
    localparam int EXECUTE_DATA_W = 80;
    localparam int SKID_CNT_W     = 16;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_BUSY:  occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   in  1      clock, rising edge
//     rst   in  1      synchronous active-low reset (count -> 0)
//     clr   in  1      clear to 0; wins over inc
//     inc   in  1      increment by one, holding at all-ones
//     count out CNT_W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//   Two-entry (main + skid) pipeline register stage with a registered
//   in_ready, flush, global run enable and a stall statistics counter.
//   Ports:
//     clk        in  1       clock, rising edge
//     rst        in  1       synchronous active-low reset
//     rdy        in  1       global run enable; 0 freezes the stage
//     flush      in  1       discard all held payloads
//     in_valid   in  1       upstream payload valid
//     in_data    in  DATA_W  upstream payload
//     in_ready   out 1       stage accepts in_data this cycle
//     out_valid  out 1       out_data valid
//     out_data   out DATA_W  payload to next stage (always main)
//     out_ready  in  1       downstream accepts out_data
//     occupancy  out 2       held payloads 0/1/2
//     stall_cnt  out CNT_W   cycles with out_valid=1 and out_ready=0
//     stat_clr   in  1       clear stall_cnt
//
//   Handshake: a transfer happens on an edge where valid and ready are both
//   1 on that side; valid never waits on ready. in_ready is derived only
//   from registered state plus rst/rdy/flush, so out_ready never reaches it
//   combinationally -- the skid register absorbs the one payload that may
//   arrive in the cycle downstream stalls.
// ---------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W = SKID_DATA_W,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = SKID_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stat_clr
);

    skid_state_e       state;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] skid_reg;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = rst && rdy && !flush && (state != ST_FULL);
    assign out_valid = rst && rdy && (state != ST_EMPTY);
    assign out_data  = main_reg;
    assign occupancy = rst ? occ_of(state) : '0;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Priority: reset > flush > rdy=0 (hold) > normal. With rdy=0 both
    // transfer strobes are 0, so the normal case arm simply holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_EMPTY;
            main_reg <= BUBBLE;
            skid_reg <= BUBBLE;
        end else if (flush) begin
            state    <= ST_EMPTY;
            main_reg <= BUBBLE;
            skid_reg <= BUBBLE;
        end else if (rdy) begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_reg <= in_data;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_reg <= in_data;
                    end else if (in_xfer) begin
                        skid_reg <= in_data;
                        state    <= ST_FULL;
                    end else if (out_xfer) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_reg <= skid_reg;
                        skid_reg <= BUBBLE;
                        state    <= ST_BUSY;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    main_reg <= BUBBLE;
                    skid_reg <= BUBBLE;
                end
            endcase
        end
    end

    // out_valid already folds in rst and rdy, so a frozen stage never counts.
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (stat_clr),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//   Directed + short random stimulus for pipe_skid_stage. A queue model of
//   the held payloads (exp_q) is pushed on modelled input transfers and
//   popped/compared on modelled output transfers.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int                W      = 16;
    localparam int                CW     = 4;
    localparam logic [W-1:0]      BUB    = 16'hBEEF;
    localparam logic [CW-1:0]     CNTMAX = {CW{1'b1}};

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          rdy = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic          stat_clr = 1'b0;

    pipe_skid_stage #(
        .DATA_W(W),
        .BUBBLE(BUB),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .stat_clr (stat_clr)
    );

    // scoreboard / model state
    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] exp_stall = '0;
    bit            bubbled = 1'b1;
    int            tests_run = 0;
    int            tests_failed = 0;
    int            delivered = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive inputs (called just after a falling edge)
    task automatic drive(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                         input logic ordy, input logic clr);
        rdy       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stat_clr  = clr;
    endtask

    // check outputs mid-cycle, advance the model across the rising edge
    task automatic cycle();
        logic e_in_ready, e_out_valid, in_x, out_x;
        logic [1:0] e_occ;
        #1;
        e_in_ready  = rst && rdy && !flush && (exp_q.size() < 2);
        e_out_valid = rst && rdy && (exp_q.size() > 0);
        e_occ       = rst ? 2'(exp_q.size()) : 2'd0;
        chk("in_ready", 32'(in_ready), 32'(e_in_ready));
        chk("out_valid", 32'(out_valid), 32'(e_out_valid));
        chk("occupancy", 32'(occupancy), 32'(e_occ));
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
        else if (bubbled)     chk("out_data_bubble", 32'(out_data), 32'(BUB));
        in_x  = in_valid && e_in_ready;
        out_x = e_out_valid && out_ready;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            bubbled   = 1'b1;
            exp_stall = '0;
        end else begin
            if (stat_clr) exp_stall = '0;
            else if (e_out_valid && !out_ready && exp_stall != CNTMAX) exp_stall = exp_stall + 1'b1;
            if (flush) begin
                exp_q.delete();
                bubbled = 1'b1;
            end else begin
                if (out_x) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
                if (in_x) begin
                    exp_q.push_back(in_data);
                    bubbled = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, ordy, 1'b0);
            cycle();
        end
    endtask

    initial begin
        int d0;
        @(negedge clk);
        // reset
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 16'h0055, 1'b1, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;

        // streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(i), 1'b1, 1'b0);
            cycle();
        end
        idle(2, 1'b1);
        chk("stream_delivered", 32'(delivered), 32'd8);

        // fill to FULL under backpressure, then drain
        drive(1'b1, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b0, 1'b1, 16'h000B, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b0, 1'b1, 16'h00DD, 1'b0, 1'b0); cycle();  // refused, FULL
        idle(2, 1'b0);
        idle(3, 1'b1);
        chk("stall_after_drain", 32'(stall_cnt), 32'd4);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1); cycle();

        // flush while FULL with a payload offered
        drive(1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0); cycle();
        drive(1'b1, 1'b1, 1'b1, 16'h000C, 1'b0, 1'b0); cycle();
        idle(3, 1'b1);

        // freeze with rdy=0 while BUSY
        drive(1'b1, 1'b0, 1'b1, 16'h0021, 1'b0, 1'b0); cycle();
        d0 = delivered;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0);
            cycle();
        end
        idle(3, 1'b1);
        chk("freeze_delivered_once", 32'(delivered - d0), 32'd1);

        // stall counter saturation, then clear
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1); cycle();
        drive(1'b1, 1'b0, 1'b1, 16'h0031, 1'b0, 1'b0); cycle();
        idle(20, 1'b0);
        chk("stall_saturated", 32'(stall_cnt), 32'(CNTMAX));
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1); cycle();
        chk("stall_cleared", 32'(stall_cnt), 32'd0);

        // reset for one cycle while FULL
        drive(1'b1, 1'b0, 1'b1, 16'h0041, 1'b0, 1'b0); cycle();
        d0 = delivered;
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); cycle();
        rst = 1'b1;
        idle(3, 1'b1);
        chk("reset_nothing_delivered", 32'(delivered - d0), 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 1)), W'($urandom_range(1, 16'hFFFE)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
            cycle();
        end
        idle(4, 1'b1);
        chk("final_empty", 32'(occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 80, SHALL set the payload width (rd_addr, rd_data, s_data, optype and opname packed by the instantiating stage).
REQ-002 Parameter BUBBLE, default all-zero DATA_W vector, SHALL be the payload value loaded on reset and flush.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 Ports, in this order (direction, width, meaning):
 clk  in  1  single clock; all state updates on its rising edge.
 rst  in  1  reset, synchronous, active-low (asserted when 0).
 rdy  in  1  global run enable; 0 freezes the stage.
 flush  in  1  kill all held payloads (branch mispredict).
 in_valid  in  1  upstream payload valid.
 in_data  in  DATA_W  upstream payload.
 in_ready  out  1  stage can accept in_data this cycle.
 out_valid  out  1  out_data valid.
 out_data  out  DATA_W  payload to the next stage.
 out_ready  in  1  downstream accepts out_data.
 occupancy  out  2  held payloads: 0, 1 or 2.
 stall_cnt  out  CNT_W  cycles in which out_valid=1 and out_ready=0.
 stat_clr  in  1  clear stall_cnt.

Function
REQ-005 The stage SHALL hold two registers, main and skid, controlled by a state machine with states EMPTY, BUSY (main valid) and FULL (main and skid valid).
REQ-006 in_ready SHALL be 1 iff rst=1, rdy=1, flush=0 and state != FULL; it SHALL depend only on registered state and these inputs, never on out_ready.
REQ-007 out_valid SHALL be 1 iff rdy=1 and state != EMPTY; out_data SHALL always equal main.
REQ-008 An input transfer occurs iff in_valid & in_ready; an output transfer occurs iff out_valid & out_ready.
REQ-009 EMPTY: input transfer -> main<=in_data, BUSY; otherwise remain.
REQ-010 BUSY: input only -> skid<=in_data, FULL; output only -> EMPTY; both -> main<=in_data, remain BUSY; neither -> remain.
REQ-011 FULL: output transfer -> main<=skid, skid<=BUBBLE, BUSY; otherwise remain.
REQ-012 Latency: a payload accepted in an EMPTY cycle SHALL appear on out_data with out_valid=1 in the next cycle; sustained throughput SHALL be one payload per cycle when out_ready stays 1.
REQ-013 flush=1 (rdy any value) SHALL set state EMPTY and main, skid to BUBBLE at the next edge; any simultaneous input is discarded; stall_cnt is unaffected.
REQ-014 rdy=0 with flush=0 SHALL hold state, main, skid and stall_cnt unchanged.
REQ-015 Priority SHALL be reset > flush > rdy=0 > normal operation.
REQ-016 occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-017 stall_cnt SHALL increment when out_valid=1 and out_ready=0, saturate at all-ones, and clear to 0 when stat_clr=1 (clear wins over increment).
REQ-018 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush or reset.

Reset
REQ-019 While rst=0 at a rising edge: state EMPTY, main and skid BUBBLE, stall_cnt 0; in_ready and out_valid SHALL read 0 while rst=0; occupancy 0.
REQ-020 Reset asserted mid-transfer SHALL discard both held payloads; the first cycle after release SHALL have in_ready=1 (if rdy=1) and out_valid=0.

Structure
REQ-021 The state encoding (EMPTY, BUSY, FULL) and the occupancy width SHALL live in the shared pipeline package; DATA_W defaults per stage SHALL be constants there.
REQ-022 The saturating, clearable stall counter SHALL be one sub-module, sat_counter, parametrised by CNT_W.

Verification
REQ-023 Stream 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, first one cycle after first accept, occupancy never exceeds 1.
REQ-024 BUSY holding 0xA, out_ready=0, send 0xB -> FULL, in_ready=0; raise out_ready -> 0xA then 0xB output, state EMPTY, stall_cnt = stalled cycles.
REQ-025 FULL, assert flush with in_valid=1 (0xC) -> next cycle EMPTY, out_valid=0, main=BUBBLE, 0xC never output.
REQ-026 BUSY, drive rdy=0 for 5 cycles with out_ready=1 -> in_ready=0, out_valid=0, payload and stall_cnt unchanged; rdy=1 -> payload delivered once.
REQ-027 CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15; stat_clr pulse -> 0.
REQ-028 rst=0 for one cycle while FULL -> EMPTY, occupancy 0, stall_cnt 0, nothing delivered.
